fb_swap_vsync_model: RTL and testbench

Simulation-side framebuffer swap and display-timing model for the Verilator top. It replaces the zero-latency `fb_swapped = !fb_swap` loopback with a parametrised display model. The model has a free-running frame/vblank timer, optional vsync-aligned swaps and a registered scan-out address. It also keeps frame, swap and missed-vblank counters that benches can read. It connects to the RasterIX `swap_fb`, `swap_fb_enable_vsync`, `fb_addr` and `fb_swapped` ports.

---
 rtl/fb_swap_vsync_model.sv | 144 ++++++++++++++
 tb/tb_fb_swap_vsync_model.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_vsync_model.sv
// -----------------------------------------------------------------------------
// fb_swap_vsync_model
//
// Simulation-side framebuffer swap and display-timing model. A free-running
// frame timer produces vblank/vsync, swap requests are committed either
// immediately or at the next vblank start, and the scan-out address is held
// in a register. Frame, swap and missed-vblank counters are exposed so a
// bench can observe display behaviour.
//
// Ports:
//   clk                  - single clock
//   rst                  - synchronous, active-high reset
//   swap_fb              - swap request, held until fb_swapped goes low
//   swap_fb_enable_vsync - 1: commit at next vblank start, 0: commit now
//   fb_addr              - new scan-out address, sampled with the request
//   fb_swapped           - 1 when idle/ready, 0 while a swap is in flight
//   vsync                - high during vblank
//   display_addr         - current scan-out address
//   frame_count          - vblank starts seen (wrapping)
//   swap_count           - committed swaps (wrapping)
//   missed_vblank_count  - vblank starts seen while idle (wrapping)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fb_swap_vsync_model #(
    parameter int                    ADDR_WIDTH      = 25,
    parameter int                    FRAME_CYCLES    = 1000,
    parameter int                    VBLANK_CYCLES   = 50,
    parameter logic [ADDR_WIDTH-1:0] FB_DEFAULT_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  swap_fb,
    input  logic                  swap_fb_enable_vsync,
    input  logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_swapped,
    output logic                  vsync,
    output logic [ADDR_WIDTH-1:0] display_addr,
    output logic [15:0]           frame_count,
    output logic [15:0]           swap_count,
    output logic [15:0]           missed_vblank_count
);

    localparam int               V_WIDTH = $clog2(FRAME_CYCLES);
    localparam logic [V_WIDTH-1:0] ACTIVE  = V_WIDTH'(FRAME_CYCLES - VBLANK_CYCLES);
    localparam logic [V_WIDTH-1:0] V_LAST  = V_WIDTH'(FRAME_CYCLES - 1);
    localparam int               NUM_COUNTERS = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VBLANK,
        COMMIT,
        RELEASE
    } state_t;

    state_t                state_reg;
    logic [V_WIDTH-1:0]    v_reg;
    logic [ADDR_WIDTH-1:0] pending_addr_reg;
    logic [ADDR_WIDTH-1:0] display_addr_reg;
    logic                  fb_swapped_reg;
    logic                  vblank_start;
    logic [NUM_COUNTERS-1:0] count_inc;

    // Single-cycle strobe at the first vblank line of every frame.
    assign vblank_start = (v_reg == ACTIVE);

    // Frame timer: free-running, never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg <= '0;
        end else if (v_reg == V_LAST) begin
            v_reg <= '0;
        end else begin
            v_reg <= v_reg + 1'b1;
        end
    end

    // Swap FSM. RELEASE waits for the requester to drop swap_fb so a held
    // level cannot launch a second swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            pending_addr_reg <= '0;
            display_addr_reg <= FB_DEFAULT_ADDR;
            fb_swapped_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (swap_fb) begin
                        pending_addr_reg <= fb_addr;
                        fb_swapped_reg   <= 1'b0;
                        state_reg        <= swap_fb_enable_vsync ? WAIT_VBLANK : COMMIT;
                    end
                end
                WAIT_VBLANK: begin
                    if (vblank_start) begin
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    display_addr_reg <= pending_addr_reg;
                    state_reg        <= RELEASE;
                end
                RELEASE: begin
                    if (!swap_fb) begin
                        fb_swapped_reg <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Counter increment conditions: frames, commits, frames repeated while idle.
    assign count_inc[0] = vblank_start;
    assign count_inc[1] = (state_reg == COMMIT);
    assign count_inc[2] = vblank_start && (state_reg == IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_counter
            logic [15:0] count_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (count_inc[gi]) begin
                    count_reg <= count_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign frame_count         = g_counter[0].count_reg;
    assign swap_count          = g_counter[1].count_reg;
    assign missed_vblank_count = g_counter[2].count_reg;

    assign fb_swapped   = fb_swapped_reg;
    assign display_addr = display_addr_reg;
    assign vsync        = (v_reg >= ACTIVE);

endmodule

// File: tb/tb_fb_swap_vsync_model.sv
// -----------------------------------------------------------------------------
// tb_fb_swap_vsync_model
//
// Directed scenarios followed by randomized swap transactions. The reference
// model works on absolute cycle numbers since reset: each request's commit
// and release times are computed arithmetically, and every cycle all DUT
// outputs are compared against those expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fb_swap_vsync_model;

    localparam int AW  = 25;
    localparam int FC  = 100;
    localparam int VB  = 10;
    localparam int ACT = FC - VB;

    logic          clk = 1'b0;
    logic          rst;
    logic          swap_fb;
    logic          swap_fb_enable_vsync;
    logic [AW-1:0] fb_addr;
    logic          fb_swapped;
    logic          vsync;
    logic [AW-1:0] display_addr;
    logic [15:0]   frame_count;
    logic [15:0]   swap_count;
    logic [15:0]   missed_vblank_count;

    fb_swap_vsync_model #(
        .ADDR_WIDTH      (AW),
        .FRAME_CYCLES    (FC),
        .VBLANK_CYCLES   (VB),
        .FB_DEFAULT_ADDR ('0)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .swap_fb              (swap_fb),
        .swap_fb_enable_vsync (swap_fb_enable_vsync),
        .fb_addr              (fb_addr),
        .fb_swapped           (fb_swapped),
        .vsync                (vsync),
        .display_addr         (display_addr),
        .frame_count          (frame_count),
        .swap_count           (swap_count),
        .missed_vblank_count  (missed_vblank_count)
    );

    always #5 clk = ~clk;

    // Reference model state (times are cycles since reset release).
    int            t;
    bit            txn_valid;
    int            req_t, commit_t, ready_t, hold_end;
    logic [AW-1:0] cur_addr, new_addr;
    int            frame_exp, swap_exp, missed_exp;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic int next_strobe(input int n);
        int s;
        s = (n / FC) * FC + ACT;
        if (s <= n) s += FC;
        return s;
    endfunction

    task automatic check_all();
        bit busy;
        busy = txn_valid && (req_t < t) && (t < ready_t);
        chk("vsync",        32'(vsync),               32'((t % FC) >= ACT));
        chk("fb_swapped",   32'(fb_swapped),          32'(!busy));
        chk("display_addr", 32'(display_addr),        32'(cur_addr));
        chk("frame_count",  32'(frame_count),         32'(frame_exp % 65536));
        chk("swap_count",   32'(swap_count),          32'(swap_exp % 65536));
        chk("missed_count", 32'(missed_vblank_count), 32'(missed_exp % 65536));
    endtask

    // Advance one clock; update the model, drive inputs for the next cycle, check.
    task automatic step();
        @(posedge clk);
        #1;
        t++;
        if (((t - 1) % FC) == ACT) begin
            frame_exp++;
            if (!(txn_valid && (req_t < t - 1) && (t - 1 < ready_t))) missed_exp++;
        end
        if (txn_valid && t == commit_t) begin
            cur_addr = new_addr;
            swap_exp++;
        end
        swap_fb              = txn_valid && (t <= hold_end);
        swap_fb_enable_vsync = 1'($urandom_range(0, 1));
        fb_addr              = AW'($urandom);
        check_all();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        swap_fb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b0;
        t          = 0;
        txn_valid  = 1'b0;
        req_t      = 0;
        commit_t   = 0;
        ready_t    = 0;
        hold_end   = -1;
        cur_addr   = '0;
        new_addr   = '0;
        frame_exp  = 0;
        swap_exp   = 0;
        missed_exp = 0;
        check_all();
    endtask

    // Start a request at the current cycle; swap_fb stays high for cycles t..t+hold.
    task automatic start_req(input bit vs, input logic [AW-1:0] a, input int hold);
        int rel;
        req_t    = t;
        hold_end = t + hold;
        commit_t = vs ? next_strobe(t) + 2 : t + 2;
        rel      = (hold_end + 1 > commit_t) ? hold_end + 1 : commit_t;
        ready_t  = rel + 1;
        new_addr = a;
        txn_valid = 1'b1;
        swap_fb              = 1'b1;
        swap_fb_enable_vsync = vs;
        fb_addr              = a;
        $display("txn: t=%0d vsync_mode=%0d addr=%0h hold=%0d commit_at=%0d ready_at=%0d",
                 t, vs, a, hold, commit_t, ready_t);
    endtask

    task automatic run_txn(input bit vs, input logic [AW-1:0] a, input int hold);
        start_req(vs, a, hold);
        while (t < ready_t) step();
    endtask

    initial begin
        rst                  = 1'b1;
        swap_fb              = 1'b0;
        swap_fb_enable_vsync = 1'b0;
        fb_addr              = '0;

        // Reset values and first vsync at cycle ACT.
        do_reset();
        chk("rst_fb_swapped", 32'(fb_swapped), 32'd1);
        chk("rst_display",    32'(display_addr), 32'd0);
        while (t < ACT - 1) step();
        chk("vsync_before_active", 32'(vsync), 32'd0);
        step();
        chk("vsync_at_active", 32'(vsync), 32'd1);

        // Immediate swap sampled at cycle 5, held through 12.
        do_reset();
        while (t < 5) step();
        start_req(1'b0, AW'(32'h100000), 7);
        step();
        chk("imm_swapped_low", 32'(fb_swapped), 32'd0);
        step();
        chk("imm_display", 32'(display_addr), 32'h100000);
        chk("imm_swap_count", 32'(swap_count), 32'd1);
        while (t < 13) step();
        chk("imm_still_low", 32'(fb_swapped), 32'd0);
        step();
        chk("imm_released", 32'(fb_swapped), 32'd1);

        // Vsync swap requested at v=20.
        do_reset();
        while (t < 20) step();
        start_req(1'b1, AW'(32'h080000), 3);
        while (t < ACT + 1) step();
        chk("vs_display_unchanged", 32'(display_addr), 32'd0);
        step();
        chk("vs_display_new", 32'(display_addr), 32'h080000);
        chk("vs_frame_count", 32'(frame_count), 32'd1);
        chk("vs_missed", 32'(missed_vblank_count), 32'd0);
        while (t < ready_t) step();

        // Request sampled on the strobe itself: counted as missed, next frame commit.
        do_reset();
        while (t < ACT) step();
        start_req(1'b1, AW'(32'h001234), 0);
        step();
        chk("edge_missed", 32'(missed_vblank_count), 32'd1);
        while (t < FC + ACT + 1) step();
        chk("edge_display_unchanged", 32'(display_addr), 32'd0);
        step();
        chk("edge_display_new", 32'(display_addr), 32'h001234);
        while (t < ready_t) step();

        // Reset while waiting for vblank discards the swap.
        do_reset();
        while (t < 20) step();
        start_req(1'b1, AW'(32'h0ABCDE), 0);
        while (t < 50) step();
        do_reset();
        chk("rstmid_display", 32'(display_addr), 32'd0);
        chk("rstmid_swapped", 32'(fb_swapped), 32'd1);
        repeat (200) step();
        chk("rstmid_swap_count", 32'(swap_count), 32'd0);

        // Idle frames are all counted as missed; a held request swaps once.
        do_reset();
        repeat (300) step();
        chk("idle_frames", 32'(frame_count), 32'd3);
        chk("idle_missed", 32'(missed_vblank_count), 32'd3);
        run_txn(1'b0, AW'(32'h1ABCDE), 49);
        chk("held_one_swap", 32'(swap_count), 32'd1);

        // Randomized back-to-back traffic.
        repeat (40) begin
            int gap;
            gap = int'($urandom_range(0, 150));
            repeat (gap) step();
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), int'($urandom_range(0, 20)));
        end
        repeat (5) step();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
